// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary datapath: FSM state encoding
// and BCD digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Input/output handshake bundle of the sequential BCD-to-binary converter.
interface bcd_to_bin_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DIGIT_W*DIGITS-1:0]   in_bcd;
  logic                        out_valid;
  logic                        out_ready;
  logic [BIN_W-1:0]            out_bin;
  logic                        out_err;

  // Producer/consumer side.
  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  // Converter side.
  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// Combinational one-digit fold step: acc*10 + d, truncated to BIN_W bits,
// with a flag for a digit outside 0..9.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]   acc_next,
  output logic               digit_bad
);

  // acc*10 as (acc*8 + acc*2); the sum wraps modulo 2^BIN_W.
  always_comb begin
    acc_next  = (acc << 3) + (acc << 1) + BIN_W'(digit);
    digit_bad = (digit > BCD_DIGIT_MAX);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential multi-digit BCD-to-binary converter. Folds one digit per
// cycle, most significant first, and presents the result on a
// valid/ready output with a sticky invalid-digit flag.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int unsigned SR_W  = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state;
  logic [SR_W-1:0]    sreg;
  logic [BIN_W-1:0]   acc;
  logic               err;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   out_bin_r;
  logic               out_err_r;

  logic [BIN_W-1:0]   acc_next;
  logic               digit_bad;
  logic               err_next;

  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc       (acc),
    .digit     (sreg[SR_W-1 -: DIGIT_W]),
    .acc_next  (acc_next),
    .digit_bad (digit_bad)
  );

  // Error flag including the digit being folded this cycle.
  always_comb begin
    err_next = err | digit_bad;
  end

  // FSM, digit shift register, accumulator and result registers.
  // The result is captured on the final fold so out_bin/out_err hold
  // steady for the whole DONE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      out_bin_r <= '0;
      out_err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg  <= bus.in_bcd;
            acc   <= '0;
            err   <= 1'b0;
            cnt   <= CNT_W'(DIGITS - 1);
            state <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_next;
          err  <= err_next;
          sreg <= sreg << DIGIT_W;
          if (cnt == '0) begin
            out_bin_r <= err_next ? '0 : acc_next;
            out_err_r <= err_next;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_bin   = out_bin_r;
    bus.out_err   = out_err_r;
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_seq;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_bin_seq #(
    .DIGITS (4),
    .BIN_W  (14)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of a conversion; returns the cycle number (relative
  // to the accept edge = cycle 0) in which out_valid is first seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_bin !== 14'd0 || bus.out_err !== 1'b0)
      $display("FAIL reset_out_regs got bin=%0d err=%0b exp bin=0 err=0", bus.out_bin, bus.out_err);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int c;
    bus.in_bcd   = 16'h0000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c != 5) $display("FAIL zero_latency got=%0d exp=5", c);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_bin !== 14'd0 || bus.out_err !== 1'b0)
      $display("FAIL zero_result got bin=%0d err=%0b exp bin=0 err=0", bus.out_bin, bus.out_err);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_1234();
    int c;
    bus.in_bcd    = 16'h1234;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL conv_in_ready got=%0b exp=0", bus.in_ready);
    else pass_cnt++;
    wait_valid(c);
    total_cnt++;
    if (c != 5) $display("FAIL b1234_latency got=%0d exp=5", c);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_bin !== 14'h04D2 || bus.out_err !== 1'b0)
      $display("FAIL b1234_result got bin=%0d err=%0b exp bin=1234 err=0", bus.out_bin, bus.out_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL b1234_release got in_ready=%0b out_valid=%0b exp 1/0", bus.in_ready, bus.out_valid);
    else pass_cnt++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c;
    bus.in_bcd    = 16'h9999;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_bcd = 16'h0042;  // next word held while busy
    wait_valid(c);
    total_cnt++;
    if (c != 5 || bus.in_ready !== 1'b0)
      $display("FAIL b9999_timing got cyc=%0d in_ready=%0b exp cyc=5 in_ready=0", c, bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_bin !== 14'h270F || bus.out_err !== 1'b0)
      $display("FAIL b9999_result got bin=%0d err=%0b exp bin=9999 err=0", bus.out_bin, bus.out_err);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%0b exp=1", bus.in_ready);
    else pass_cnt++;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c != 5) $display("FAIL b0042_latency got=%0d exp=5", c);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_bin !== 14'd42 || bus.out_err !== 1'b0)
      $display("FAIL b0042_result got bin=%0d err=%0b exp bin=42 err=0", bus.out_bin, bus.out_err);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_invalid_digit();
    int c;
    bus.in_bcd    = 16'h12A4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c != 5 || bus.out_bin !== 14'd0 || bus.out_err !== 1'b1)
      $display("FAIL b12A4_result got cyc=%0d bin=%0d err=%0b exp cyc=5 bin=0 err=1", c, bus.out_bin, bus.out_err);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_bcd    = 16'h0007;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(c);
    total_cnt++;
    if (c != 5 || bus.out_bin !== 14'd7 || bus.out_err !== 1'b0)
      $display("FAIL b0007_result got cyc=%0d bin=%0d err=%0b exp cyc=5 bin=7 err=0", c, bus.out_bin, bus.out_err);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int c;
    bus.in_bcd    = 16'h0815;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(c);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_bin !== 14'd815 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b0)
        $display("FAIL stall_hold[%0d] got valid=%0b bin=%0d err=%0b in_ready=%0b exp 1/815/0/0",
                 i, bus.out_valid, bus.out_bin, bus.out_err, bus.in_ready);
      else pass_cnt++;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL stall_single_xfer got valid=%0b in_ready=%0b exp 0/1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int outs;
    bus.in_bcd    = 16'h5678;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;   // asserted in cycle 2 of CONV
    tick();
    rst = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bin !== 14'd0 || bus.out_err !== 1'b0)
      $display("FAIL midrst_state got in_ready=%0b valid=%0b bin=%0d err=%0b exp 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_bin, bus.out_err);
    else pass_cnt++;
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) outs++;
      tick();
    end
    // reset must also win over a simultaneous input handshake
    rst          = 1'b1;
    bus.in_bcd   = 16'h1111;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) outs++;
      tick();
    end
    total_cnt++;
    if (outs != 0) $display("FAIL midrst_no_output got=%0d exp=0", outs);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_1234();
    test_back_to_back();
    test_invalid_digit();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential multi-digit BCD-to-binary converter: the reverse direction of the team's combinational 4-bit BCD code converter. It accepts a packed BCD word through a valid/ready handshake and folds one digit per cycle, most significant digit first, into a binary accumulator (acc = acc*10 + digit). It returns the binary result with an error flag through a second valid/ready handshake. It sits between BCD-producing front ends (keypad/display logic) and binary arithmetic datapaths.

## Interface
- DIGITS, 4: number of BCD digits per input word; must be ≥1.
- BIN_W, 14: output width; must satisfy 2^BIN_W ≥ 10^DIGITS (14 for 4 digits).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bcd holds a word to convert.
- in_ready  output  1  block can accept a word.
- in_bcd  input  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k]; digit DIGITS-1 is most significant.
- out_valid  output  1  out_bin/out_err hold a completed result.
- out_ready  input  1  consumer takes the result.
- out_bin  output  BIN_W  binary value of the input.
- out_err  output  1  at least one digit was >9.

## Operation
- States: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the block latches in_bcd into a shift register, clears acc and err, loads digit counter = DIGITS-1, and goes to CONV.
- CONV: each cycle it takes the top nibble d.
  - acc <= (acc<<3) + (acc<<1) + d, truncated to BIN_W bits.
  - If d > 9, err <= 1 (sticky for this conversion).
  - The shift register shifts left by 4.
  - When the counter reaches 0, the state moves to DONE; otherwise the counter decrements.
- DONE: out_valid=1. out_bin = err ? 0 : acc. out_err = err. On out_ready, the state returns to IDLE.
- in_ready=0 in CONV and DONE; in_valid there is ignored and must be held by the producer.
- out_valid, out_bin and out_err are stable while out_valid=1 and out_ready=0.
- Arithmetic is modulo 2^BIN_W. When the BIN_W constraint holds, overflow is impossible. If an invalid digit causes overflow, it is masked because out_bin is forced to 0.
- Reset values: state IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_bin=0, out_err=0, acc=0, counter=0.
- Reset mid-operation (CONV or DONE): the pending word and result are discarded, and no out_valid pulse follows.
- rst has priority over any handshake in the same cycle.

## Timing
- Accept edge = cycle 0. CONV occupies cycles 1..DIGITS. out_valid rises at the edge ending cycle DIGITS and is visible in cycle DIGITS+1 (cycle 5 for DIGITS=4).
- Output handshake in cycle T → in_ready=1 in cycle T+1. Minimum issue interval is DIGITS+2 cycles.
- in_ready, out_valid and the output registers are driven from registered state only; there are no combinational paths from in_valid/out_ready to outputs.
- out_ready held high before DONE is harmless; the result is consumed in the first DONE cycle.

## Structure
- Shared package bcd_pkg:
  - state enum (IDLE, CONV, DONE)
  - constant BCD_DIGIT_MAX = 9
  - constant DIGIT_W = 4
- One sub-module, bcd_digit_mac: combinational acc*10 + d with BIN_W truncation and a d > BCD_DIGIT_MAX flag. It is reusable by a future binary-to-BCD checker.
- The top level holds the FSM, shift register, counter, acc, err and output registers.

## Test plan
- Reset, then in_bcd=0x0000 accepted → out_valid in cycle 5, out_bin=0, out_err=0.
- in_bcd=0x1234 accepted in cycle 0, out_ready=1 → out_bin=1234 (0x4D2) in cycle 5, in_ready=1 in cycle 6.
- in_bcd=0x9999 → out_bin=9999 (0x270F), out_err=0; back-to-back word 0x0042 held on in_valid is accepted only after the output handshake → out_bin=42.
- in_bcd=0x12A4 → out_err=1, out_bin=0; next word 0x0007 → out_err=0, out_bin=7 (err cleared per conversion).
- out_ready low for 3 cycles in DONE → out_valid, out_bin and out_err stable all 3 cycles; in_ready=0 throughout; a single transfer occurs.
- rst asserted in cycle 2 of CONV for 0x5678 → next cycle: IDLE, in_ready=1, out_valid=0, out_bin=0, and no result emitted afterward.
